// File: rtl/vga_sync_decoder_pkg.sv
// VGA timing package: default 640x480@60 timing, decoder FSM state type and
// saturating counter helpers shared by the sync decoder and the video generator.
package vga_sync_decoder_pkg;

  localparam int unsigned VGA_H_VISIBLE = 640;
  localparam int unsigned VGA_H_FRONT   = 16;
  localparam int unsigned VGA_H_SYNC    = 96;
  localparam int unsigned VGA_H_BACK    = 48;

  localparam int unsigned VGA_V_VISIBLE = 480;
  localparam int unsigned VGA_V_FRONT   = 10;
  localparam int unsigned VGA_V_SYNC    = 2;
  localparam int unsigned VGA_V_BACK    = 33;

  localparam int unsigned HCNT_W = 11;
  localparam int unsigned VCNT_W = 10;
  localparam int unsigned ERR_W  = 8;

  typedef enum logic [1:0] {
    ST_SEARCH  = 2'd0,
    ST_MEASURE = 2'd1,
    ST_LOCKED  = 2'd2
  } sync_state_e;

  function automatic logic [HCNT_W-1:0] sat_inc_h(input logic [HCNT_W-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

  function automatic logic [VCNT_W-1:0] sat_inc_v(input logic [VCNT_W-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

  function automatic logic [ERR_W-1:0] sat_inc_err(input logic [ERR_W-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/vga_sync_decoder_sync_edge_detect.sv
// Two-flop synchronizer for an active-low sync input with a falling-edge pulse.
module sync_edge_detect (
  input  logic clk,
  input  logic rst_n,
  input  logic async_in,
  output logic fall
);

  logic meta;
  logic level;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta  <= 1'b1;
      level <= 1'b1;
    end else begin
      meta  <= async_in;
      level <= meta;
    end
  end

  // Flag the edge in the cycle the second stage is about to take the low
  // value, so counters clear together with the synchronized level.
  assign fall = level & ~meta;

endmodule

// File: rtl/vga_sync_decoder.sv
// VGA sync decoder: measures HSYNC/VSYNC timing, locks onto the expected
// raster and regenerates DE, pixel coordinates and a frame-start pulse.
module vga_sync_decoder
  import vga_sync_decoder_pkg::*;
#(
  parameter int unsigned H_VISIBLE = VGA_H_VISIBLE,
  parameter int unsigned H_FRONT   = VGA_H_FRONT,
  parameter int unsigned H_SYNC    = VGA_H_SYNC,
  parameter int unsigned H_BACK    = VGA_H_BACK,
  parameter int unsigned V_VISIBLE = VGA_V_VISIBLE,
  parameter int unsigned V_FRONT   = VGA_V_FRONT,
  parameter int unsigned V_SYNC    = VGA_V_SYNC,
  parameter int unsigned V_BACK    = VGA_V_BACK
) (
  input  logic        CLK_25MHZ,
  input  logic        RESET_N,
  input  logic        VGA_HSYNC,
  input  logic        VGA_VSYNC,
  output logic        LOCKED,
  output logic        DE,
  output logic [9:0]  X,
  output logic [9:0]  Y,
  output logic        FRAME_START,
  output logic [10:0] LINE_LEN,
  output logic [7:0]  ERR_COUNT
);

  localparam int unsigned HT = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int unsigned VT = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  localparam logic [HCNT_W-1:0] HT_CNT     = HCNT_W'(HT);
  localparam logic [HCNT_W-1:0] HT_LAST    = HCNT_W'(HT - 1);
  localparam logic [VCNT_W-1:0] VT_LAST    = VCNT_W'(VT - 1);
  localparam logic [HCNT_W-1:0] H_DE_START = HCNT_W'(H_SYNC + H_BACK);
  localparam logic [HCNT_W-1:0] H_DE_END   = HCNT_W'(H_SYNC + H_BACK + H_VISIBLE);
  localparam logic [VCNT_W-1:0] V_DE_START = VCNT_W'(V_SYNC + V_BACK);
  localparam logic [VCNT_W-1:0] V_DE_END   = VCNT_W'(V_SYNC + V_BACK + V_VISIBLE);

  logic              h_fall;
  logic              v_fall;
  logic              v_pending;
  logic              v_edge;
  logic [HCNT_W-1:0] hcnt;
  logic [VCNT_W-1:0] vcnt;
  logic [HCNT_W-1:0] line_len;
  logic [ERR_W-1:0]  err_cnt;

  sync_state_e state;
  sync_state_e state_nxt;
  logic        frame_bad;
  logic        frame_bad_nxt;
  logic        err_inc;

  logic              line_ok;
  logic              frame_ok;
  logic              h_timeout;
  logic              de_nxt;
  logic [HCNT_W-1:0] x_full;
  logic [VCNT_W-1:0] y_full;

  sync_edge_detect u_hsync (
    .clk      (CLK_25MHZ),
    .rst_n    (RESET_N),
    .async_in (VGA_HSYNC),
    .fall     (h_fall)
  );

  sync_edge_detect u_vsync (
    .clk      (CLK_25MHZ),
    .rst_n    (RESET_N),
    .async_in (VGA_VSYNC),
    .fall     (v_fall)
  );

  // VSYNC is only acted on at line boundaries: a fall seen since the last
  // HSYNC edge (or coincident with it) starts a new frame at that edge.
  assign v_edge = h_fall & (v_fall | v_pending);

  assign line_ok   = (hcnt == HT_LAST);
  assign frame_ok  = (vcnt == VT_LAST);
  assign h_timeout = !h_fall && (hcnt == HT_CNT);

  always_ff @(posedge CLK_25MHZ or negedge RESET_N) begin
    if (!RESET_N) begin
      hcnt      <= '0;
      vcnt      <= '0;
      line_len  <= '0;
      v_pending <= 1'b0;
    end else begin
      if (h_fall) begin
        hcnt      <= '0;
        line_len  <= sat_inc_h(hcnt);
        v_pending <= 1'b0;
        vcnt      <= v_edge ? '0 : sat_inc_v(vcnt);
      end else begin
        hcnt <= sat_inc_h(hcnt);
        if (v_fall) begin
          v_pending <= 1'b1;
        end
      end
    end
  end

  // The line ending at a VSYNC edge is checked as part of the old frame
  // before the per-frame flag is cleared for the new one.
  always_comb begin
    state_nxt     = state;
    frame_bad_nxt = frame_bad;
    err_inc       = 1'b0;
    if (h_fall && !line_ok) begin
      frame_bad_nxt = 1'b1;
    end
    case (state)
      ST_SEARCH: begin
        if (v_edge) begin
          state_nxt     = ST_MEASURE;
          frame_bad_nxt = 1'b0;
        end
      end
      ST_MEASURE: begin
        if (v_edge) begin
          frame_bad_nxt = 1'b0;
          if (!frame_bad && line_ok && frame_ok) begin
            state_nxt = ST_LOCKED;
          end else begin
            err_inc = 1'b1;
          end
        end
      end
      ST_LOCKED: begin
        if ((h_fall && !line_ok) || h_timeout || (v_edge && !frame_ok)) begin
          state_nxt = ST_SEARCH;
          err_inc   = 1'b1;
        end
      end
      default: begin
        state_nxt     = ST_SEARCH;
        frame_bad_nxt = 1'b0;
      end
    endcase
  end

  always_ff @(posedge CLK_25MHZ or negedge RESET_N) begin
    if (!RESET_N) begin
      state     <= ST_SEARCH;
      frame_bad <= 1'b0;
      err_cnt   <= '0;
    end else begin
      state     <= state_nxt;
      frame_bad <= frame_bad_nxt;
      if (err_inc) begin
        err_cnt <= sat_inc_err(err_cnt);
      end
    end
  end

  always_comb begin
    de_nxt = (state == ST_LOCKED) &&
             (hcnt >= H_DE_START) && (hcnt < H_DE_END) &&
             (vcnt >= V_DE_START) && (vcnt < V_DE_END);
    x_full = hcnt - H_DE_START;
    y_full = vcnt - V_DE_START;
  end

  always_ff @(posedge CLK_25MHZ or negedge RESET_N) begin
    if (!RESET_N) begin
      LOCKED      <= 1'b0;
      DE          <= 1'b0;
      X           <= '0;
      Y           <= '0;
      FRAME_START <= 1'b0;
    end else begin
      LOCKED      <= (state_nxt == ST_LOCKED);
      DE          <= de_nxt;
      X           <= de_nxt ? x_full[9:0] : '0;
      Y           <= de_nxt ? y_full : '0;
      FRAME_START <= de_nxt && (hcnt == H_DE_START) && (vcnt == V_DE_START);
    end
  end

  assign LINE_LEN  = line_len;
  assign ERR_COUNT = err_cnt;

endmodule
